// File: rtl/des_sbox_unit_if.sv
// Handshake bundle for the DES substitution stage: 48-bit keyed word in, 32-bit S-box word out.
interface des_sbox_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/des_sbox_unit.sv
// Multi-cycle DES S1..S8 substitution, LANES boxes per clock, valid/ready on both sides.
module des_sbox_unit #(
    parameter int unsigned LANES = 8
) (
    input  logic            ck,
    input  logic            rst,
    des_sbox_unit_if.slave  bus
);
    localparam int unsigned NBOX = 8;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
    end

    // Tables packed row-major (row*16+col), entry 0 in the top nibble.
    localparam logic [255:0] S1_T = 256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D;
    localparam logic [255:0] S2_T = 256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9;
    localparam logic [255:0] S3_T = 256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C;
    localparam logic [255:0] S4_T = 256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E;
    localparam logic [255:0] S5_T = 256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453;
    localparam logic [255:0] S6_T = 256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D;
    localparam logic [255:0] S7_T = 256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C;
    localparam logic [255:0] S8_T = 256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [47:0] latch;
    logic [31:0] acc;
    logic [31:0] acc_next;
    logic [2:0]  idx;
    logic        out_valid_q;
    logic        busy_q;
    logic        in_ready;
    logic        accept;
    logic        last_step;

    function automatic logic [3:0] sbox(input logic [2:0] k, input logic [5:0] b);
        logic [255:0] t;
        logic [5:0]   e;
        t = '0;
        e = {b[5], b[0], b[4:1]};
        case (k)
            3'd0: t = S1_T;
            3'd1: t = S2_T;
            3'd2: t = S3_T;
            3'd3: t = S4_T;
            3'd4: t = S5_T;
            3'd5: t = S6_T;
            3'd6: t = S7_T;
            3'd7: t = S8_T;
            default: t = '0;
        endcase
        return t[{~e, 2'b00} +: 4];
    endfunction

    assign last_step = (idx == 3'(NBOX - LANES));
    assign accept    = bus.in_valid & in_ready;

    // State register
    always_ff @(posedge ck or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.in_valid) state_next = RUN;
            RUN:  if (last_step)    state_next = DONE;
            DONE: if (bus.out_ready) state_next = bus.in_valid ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: in_ready depends only on state and out_ready
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = bus.out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Evaluate this cycle's LANES boxes into a copy of the accumulator
    always_comb begin
        logic [2:0] box;
        logic [2:0] sel;
        acc_next = acc;
        box      = '0;
        sel      = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            box = idx + 3'(l);
            sel = 3'(7) - box;
            acc_next[{sel, 2'b00} +: 4] = sbox(box, latch[6'(sel) * 6'd6 +: 6]);
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            latch       <= '0;
            acc         <= '0;
            idx         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            if (accept) begin
                latch <= bus.in_data;
                acc   <= '0;
                idx   <= '0;
            end else if (state == RUN) begin
                acc <= acc_next;
                idx <= idx + 3'(LANES);
            end
            out_valid_q <= (state_next == DONE);
            busy_q      <= (state_next != IDLE);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_des_sbox_unit.sv
// Bench: four instances (LANES 1,2,4,8) share one stimulus; directed table, corner sequences, exhaustive ROM sweep.
module tb_des_sbox_unit;
    logic ck = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic [47:0] in_data;

    logic [3:0]        ir;
    logic [3:0]        ov;
    logic [3:0]        bz;
    logic [3:0][31:0]  od;

    always #5 ck = ~ck;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        des_sbox_unit_if bus ();
        assign bus.in_valid  = in_valid;
        assign bus.in_data   = in_data;
        assign bus.out_ready = out_ready;
        assign ir[g] = bus.in_ready;
        assign ov[g] = bus.out_valid;
        assign bz[g] = bus.busy;
        assign od[g] = bus.out_data;
        des_sbox_unit #(.LANES(32'(1) << g)) dut (
            .ck  (ck),
            .rst (rst),
            .bus (bus)
        );
    end

    int passed = 0;
    int total  = 0;
    int unsigned sb [8][64];

    typedef struct {
        logic [47:0] din;
        logic [31:0] expv;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    function automatic logic [31:0] model(input logic [47:0] d);
        logic [31:0] m;
        logic [5:0]  b;
        int          r;
        m = '0;
        for (int k = 0; k < 8; k++) begin
            b = d[(7 - k) * 6 +: 6];
            r = {26'd0, b[5], b[0], b[4:1]};
            m[(7 - k) * 4 +: 4] = 4'(sb[k][r]);
        end
        return m;
    endfunction

    // Called at accept edge + 1; tracks each lane's latency, result and busy span.
    task automatic observe(input logic [31:0] expv);
        int          lat [4];
        int          bc  [4];
        logic [31:0] got [4];
        for (int g = 0; g < 4; g++) begin
            lat[g] = -1;
            bc[g]  = 0;
            got[g] = '0;
        end
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) begin
                @(posedge ck);
                #1;
            end
            for (int g = 0; g < 4; g++) begin
                if (ov[g] && lat[g] < 0) begin
                    lat[g] = c;
                    got[g] = od[g];
                end
                if (bz[g]) bc[g]++;
            end
        end
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("latency L%0d", 1 << g), 128'(lat[g]), 128'(8 >> g));
            chk($sformatf("data L%0d din=%0h", 1 << g, in_data), 128'(got[g]), 128'(expv));
            chk($sformatf("busy_cycles L%0d", 1 << g), 128'(bc[g]), 128'((8 >> g) + 1));
        end
        chk("idle_after", 128'(ov), 128'(0));
    endtask

    task automatic run(input logic [47:0] din, input logic [31:0] expv);
        @(negedge ck);
        in_data   = din;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("in_ready_idle", 128'(ir), 128'hF);
        @(posedge ck);
        #1;
        in_valid = 1'b0;
        observe(expv);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] wa;
        logic [47:0] wb;
        logic [47:0] din;

        sb = '{
            '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
            '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
            '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
            '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
            '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
            '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
            '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
            '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
        };

        vecs[0] = '{din: 48'h000000000000, expv: 32'hEFA72C4D};
        vecs[1] = '{din: 48'hFFFFFFFFFFFF, expv: 32'hD9CE3DCB};
        vecs[2] = '{din: 48'h080000000000, expv: 32'h4FA72C4D};
        vecs[3] = '{din: 48'h00000000003F, expv: 32'hEFA72C4B};
        vecs[4] = '{din: 48'h000000840000, expv: 32'hEFA7BC4D};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge ck);
        @(negedge ck);
        rst = 1'b0;
        #1;
        chk("reset in_ready", 128'(ir), 128'hF);
        chk("reset out_valid", 128'(ov), 128'h0);
        chk("reset out_data", 128'(od), 128'h0);
        chk("reset busy", 128'(bz), 128'h0);

        // Directed table
        for (int i = 0; i < 5; i++) run(vecs[i].din, vecs[i].expv);

        // Backpressure: stall in DONE with a new word pending, then release
        wa = 48'h123456789ABC;
        wb = 48'h0F0F0F0F0F0F;
        @(negedge ck);
        in_data   = wa;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge ck);
        #1;
        in_data = wb;
        repeat (8) @(posedge ck);
        for (int c = 0; c < 5; c++) begin
            @(posedge ck);
            #1;
            chk("stall out_valid", 128'(ov), 128'hF);
            chk("stall in_ready", 128'(ir), 128'h0);
            chk("stall out_data", 128'(od), {4{model(wa)}});
        end
        @(negedge ck);
        out_ready = 1'b1;
        #1;
        chk("release in_ready", 128'(ir), 128'hF);
        @(posedge ck);
        #1;
        in_valid = 1'b0;
        observe(model(wb));

        // Reset while LANES=1 is at idx=4
        @(negedge ck);
        in_data   = 48'hFFFFFFFFFFFF;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge ck);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge ck);
        #2;
        chk("mid busy L1", 128'(bz[0]), 128'h1);
        rst = 1'b1;
        #1;
        chk("async out_valid", 128'(ov), 128'h0);
        chk("async out_data", 128'(od), 128'h0);
        chk("async busy", 128'(bz), 128'h0);
        chk("async in_ready", 128'(ir), 128'hF);
        @(posedge ck);
        @(negedge ck);
        rst = 1'b0;
        repeat (9) @(posedge ck);
        #1;
        chk("no partial result", 128'(ov), 128'h0);
        run(48'h0, 32'hEFA72C4D);

        // Exhaustive ROM sweep, one box active at a time
        for (int k = 0; k < 8; k++) begin
            for (int v = 0; v < 64; v++) begin
                din = 48'(v) << (6 * (7 - k));
                run(din, model(din));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
